stack_seq_ctrl: RTL and testbench
=================================

Name: stack_seq_ctrl

Overview:
- Multi-cycle sequencer directly upstream of the stack push/pop/SP block.
- Converts one decoded stack-class instruction (PUSH, POP, CALL, RET, INT, RTI) into a cycle-by-cycle series of single-word stack operations.
- Drives stackOp/pushPop into the SP logic and the data-memory write/read controls.
- Reassembles popped words into PC/flags/register results, and stalls the front-end while the sequence runs.

Parameters:
- DATA_W, 16, data-memory word width.
- PC_W, 32, program-counter width (2 words).
- FLAGS_W, 3, flag register width, zero-extended to DATA_W in memory.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; opType/operands valid with it.
- opType  in  3  0=PUSH 1=POP 2=CALL 3=RET 4=INT 5=RTI; 6,7 illegal.
- pcIn  in  PC_W  return PC to save (CALL/INT).
- dataIn  in  DATA_W  register value to push (PUSH).
- flagsIn  in  FLAGS_W  flags to save (INT).
- memReadData  in  DATA_W  data memory read result, valid one cycle after memRead.
- stackOp  out  1  SP update enable to push/pop logic.
- pushPop  out  1  1=push, 0=pop.
- memWrite  out  1  data memory write enable.
- memRead  out  1  data memory read enable.
- memWriteData  out  DATA_W  word to push.
- busy  out  1  sequence in progress.
- stall  out  1  front-end stall, = start | busy (combinational).
- done  out  1  one-cycle completion pulse.
- popValid  out  1  popData valid (POP only, same cycle as done).
- popData  out  DATA_W  popped register value.
- pcLoad  out  1  load pcOut into PC (RET/RTI, with done).
- pcOut  out  PC_W  reassembled return PC.
- flagsLoad  out  1  load flagsOut (RTI, with done).
- flagsOut  out  FLAGS_W  restored flags.

Behaviour:
- Reset, asynchronous while reset==0: state=IDLE; every registered output is 0 (stackOp, pushPop, memWrite, memRead, memWriteData, busy, done, popValid, popData, pcLoad, pcOut, flagsLoad, flagsOut).
- Reset mid-sequence aborts immediately. Already-issued SP updates are not unwound.
- Accept: start=1 in IDLE with a legal opType. opType/pcIn/dataIn/flagsIn are snapshotted at edge E0. start while busy, and illegal opType, are ignored: no state change.
- Step table, in issue order:
  - PUSH: push dataIn.
  - CALL: push PC[31:16], push PC[15:0].
  - INT: push PC[31:16], push PC[15:0], push flags (zero-extended).
  - POP: pop -> popData.
  - RET: pop PC[15:0], pop PC[31:16].
  - RTI: pop flags, pop PC[15:0], pop PC[31:16].
- Issue timing: with N steps, step k is issued in cycle k after E0 (k=0..N-1). Each issue cycle has stackOp=1 and pushPop=1/0, plus memWrite with memWriteData (push) or memRead (pop). Exactly one SP operation per cycle.
- Pop data: the read issued in cycle k is captured from memReadData at the end of cycle k+1. Capture is pipelined under the next issue.
- FSM: IDLE -> PUSH_SEQ or POP_SEQ on accept. Step counter is 2 bits.
  - PUSH_SEQ -> FINISH after step N-1.
  - POP_SEQ -> POP_DRAIN after step N-1. POP_DRAIN captures the last word -> FINISH.
  - FINISH -> IDLE.
- FINISH cycle: done=1. For pop-class ops, pcLoad/flagsLoad/popValid=1 with outputs stable.
- Latency, E0 to done: push-class N cycles; pop-class N+1 cycles.
- busy=1 from cycle 0 through the done cycle inclusive.
- A new start may be accepted at the edge ending FINISH. There are no back-to-back bubbles beyond that.
- flagsOut = low FLAGS_W bits of the popped word; the upper bits are discarded.

Optional Feature:
- STACK_GUARD_EN defined:
  - Adds input StackOverFlow (1) from the SP block and output stackFault (1).
  - If StackOverFlow=1 during any issue cycle, the remaining steps are not issued (stackOp=0 from the next cycle).
  - stackFault pulses one cycle with done. pcLoad/flagsLoad/popValid stay 0.
  - FSM returns to IDLE.
- STACK_GUARD_EN undefined: no such ports; sequences always run to completion.

Decomposition:
- Shared package/header `stack_defs`: opType encodings, FSM state encodings, step-count constants (PUSH=1, CALL=2, INT=3, etc.), DATA_W/PC_W/FLAGS_W defaults.
- One natural sub-module, `stack_word_asm`: pop-capture register file. It assembles lo/hi PC halves and flags from memReadData under a step index.

Test Plan:
- Reset asserted mid-INT at step 1 -> all outputs 0 immediately; after release, start PUSH dataIn=16'hBEEF -> one push cycle with memWriteData=BEEF, done on cycle 1.
- CALL pcIn=32'h0012_3456 -> cycle0 push 0012, cycle1 push 3456, done cycle2, stall high throughout, no pcLoad.
- RET with memory returning 3456 then 0012 -> two pops, pcOut=32'h0012_3456, pcLoad+done in cycle 3.
- INT pcIn=32'hAAAA_5555 flagsIn=3'b101, then RTI -> pushes AAAA,5555,0005; RTI restores flagsOut=101, pcOut=AAAA_5555.
- start during busy and opType=7 in IDLE -> ignored, no stackOp, busy unchanged.
- STACK_GUARD_EN: StackOverFlow=1 in cycle0 of CALL -> no second push, stackFault+done in cycle1, back to IDLE.

Source files
------------

// File: rtl/stack_defs.sv
`default_nettype none
//============================================================================
// Package     : stack_defs
// Description : Shared definitions for the stack sequencer. Holds the opType
//               encodings, FSM state encodings, per-operation step counts,
//               pop-capture roles and default data/PC/flag widths.
// Revision    : 1.0  initial release
//============================================================================
package stack_defs;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_PC_W    = 32;
  localparam int DEF_FLAGS_W = 3;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_INT  = 3'd4,
    OP_RTI  = 3'd5
  } opType_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PUSH_SEQ  = 3'd1,
    ST_POP_SEQ   = 3'd2,
    ST_POP_DRAIN = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  // Destination of a popped word inside the capture register file.
  typedef enum logic [1:0] {
    CAP_DATA  = 2'd0,
    CAP_PC_LO = 2'd1,
    CAP_PC_HI = 2'd2,
    CAP_FLAGS = 2'd3
  } capSel_e;

  localparam logic [1:0] STEPS_PUSH = 2'd1;
  localparam logic [1:0] STEPS_POP  = 2'd1;
  localparam logic [1:0] STEPS_CALL = 2'd2;
  localparam logic [1:0] STEPS_RET  = 2'd2;
  localparam logic [1:0] STEPS_INT  = 2'd3;
  localparam logic [1:0] STEPS_RTI  = 2'd3;

  function automatic logic isLegalOp(input logic [2:0] op);
    return (op <= OP_RTI);
  endfunction

  function automatic logic isPopOp(input logic [2:0] op);
    return (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
  endfunction

  function automatic logic [1:0] stepCount(input logic [2:0] op);
    logic [1:0] n;
    case (op)
      OP_PUSH: n = STEPS_PUSH;
      OP_POP:  n = STEPS_POP;
      OP_CALL: n = STEPS_CALL;
      OP_RET:  n = STEPS_RET;
      OP_INT:  n = STEPS_INT;
      default: n = STEPS_RTI;
    endcase
    return n;
  endfunction

  // Pops come off in reverse push order: flags first (RTI), then PC low,
  // then PC high.
  function automatic capSel_e popRole(input logic [2:0] op, input logic [1:0] idx);
    capSel_e role;
    role = CAP_DATA;
    if (op == OP_RET) begin
      role = (idx == 2'd0) ? CAP_PC_LO : CAP_PC_HI;
    end else if (op == OP_RTI) begin
      case (idx)
        2'd0:    role = CAP_FLAGS;
        2'd1:    role = CAP_PC_LO;
        default: role = CAP_PC_HI;
      endcase
    end
    return role;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_word_asm.sv
`default_nettype none
//============================================================================
// Module      : stack_word_asm
// Description : Pop-capture register file. Latches memReadData into the
//               register selected by capSel (popped data word, PC low half,
//               PC high half or flags) and presents the reassembled values.
// Revision    : 1.0  initial release
// Ports       : clk, reset (async active-low), capEn, capSel[1:0],
//               memReadData[DATA_W] -> popData[DATA_W], pcOut[PC_W],
//               flagsOut[FLAGS_W]
//============================================================================
module stack_word_asm
  import stack_defs::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int FLAGS_W = DEF_FLAGS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capEn,
  input  logic [1:0]         capSel,
  input  logic [DATA_W-1:0]  memReadData,
  output logic [DATA_W-1:0]  popData,
  output logic [PC_W-1:0]    pcOut,
  output logic [FLAGS_W-1:0] flagsOut
);

  logic [DATA_W-1:0]  r_popData;
  logic [DATA_W-1:0]  r_pcLo;
  logic [DATA_W-1:0]  r_pcHi;
  logic [FLAGS_W-1:0] r_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_popData <= '0;
      r_pcLo    <= '0;
      r_pcHi    <= '0;
      r_flags   <= '0;
    end else if (capEn) begin
      case (capSel)
        CAP_DATA:  r_popData <= memReadData;
        CAP_PC_LO: r_pcLo    <= memReadData;
        CAP_PC_HI: r_pcHi    <= memReadData;
        default:   r_flags   <= memReadData[FLAGS_W-1:0]; // upper bits dropped
      endcase
    end
  end

  assign popData  = r_popData;
  assign pcOut    = {r_pcHi, r_pcLo};
  assign flagsOut = r_flags;

endmodule
`default_nettype wire

// File: rtl/stack_seq_ctrl.sv
`default_nettype none
//============================================================================
// Module      : stack_seq_ctrl
// Description : Multi-cycle sequencer for PUSH/POP/CALL/RET/INT/RTI. Issues
//               one single-word stack operation per cycle toward the SP
//               block and data memory, reassembles popped words into
//               PC/flags/register results and stalls the front-end.
// Revision    : 1.0  initial release
// Ports       : clk, reset (async active-low), start, opType[2:0],
//               pcIn[PC_W], dataIn[DATA_W], flagsIn[FLAGS_W],
//               memReadData[DATA_W] ->
//               stackOp, pushPop, memWrite, memRead, memWriteData[DATA_W],
//               busy, stall, done, popValid, popData[DATA_W], pcLoad,
//               pcOut[PC_W], flagsLoad, flagsOut[FLAGS_W]
// Options     : STACK_GUARD_EN adds input StackOverFlow and output
//               stackFault; an overflow during any issue cycle aborts the
//               remaining steps and ends with done+stackFault.
//============================================================================
module stack_seq_ctrl
  import stack_defs::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int FLAGS_W = DEF_FLAGS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         opType,
  input  logic [PC_W-1:0]    pcIn,
  input  logic [DATA_W-1:0]  dataIn,
  input  logic [FLAGS_W-1:0] flagsIn,
  input  logic [DATA_W-1:0]  memReadData,
`ifdef STACK_GUARD_EN
  input  logic               StackOverFlow,
  output logic               stackFault,
`endif
  output logic               stackOp,
  output logic               pushPop,
  output logic               memWrite,
  output logic               memRead,
  output logic [DATA_W-1:0]  memWriteData,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic               popValid,
  output logic [DATA_W-1:0]  popData,
  output logic               pcLoad,
  output logic [PC_W-1:0]    pcOut,
  output logic               flagsLoad,
  output logic [FLAGS_W-1:0] flagsOut
);

  // Word pushed at step idx: PUSH carries the register value; CALL/INT push
  // PC high, PC low, then (INT only) zero-extended flags.
  function automatic logic [DATA_W-1:0] pushWord(
    input logic [2:0]         op,
    input logic [1:0]         idx,
    input logic [PC_W-1:0]    pc,
    input logic [DATA_W-1:0]  data,
    input logic [FLAGS_W-1:0] flags
  );
    logic [DATA_W-1:0] w;
    w = data;
    if (op != OP_PUSH) begin
      case (idx)
        2'd0:    w = pc[PC_W-1:DATA_W];
        2'd1:    w = pc[DATA_W-1:0];
        default: w = {{(DATA_W-FLAGS_W){1'b0}}, flags};
      endcase
    end
    return w;
  endfunction

  state_e             r_state, w_nextState;
  logic [1:0]         r_stepCnt, w_nextStep, w_stepInc;
  logic [2:0]         r_op;
  logic [PC_W-1:0]    r_pc;
  logic [FLAGS_W-1:0] r_flags;

  logic               r_stackOp, w_nextStackOp;
  logic               r_pushPop, w_nextPushPop;
  logic               r_memWrite, w_nextMemWrite;
  logic               r_memRead, w_nextMemRead;
  logic [DATA_W-1:0]  r_memWriteData, w_nextMemWriteData;
  logic               r_busy;
  logic               r_done, w_nextDone;
  logic               r_popValid, w_nextPopValid;
  logic               r_pcLoad, w_nextPcLoad;
  logic               r_flagsLoad, w_nextFlagsLoad;

  logic               w_accept;
  logic               w_lastStep;
  logic               w_capEn;
  logic [1:0]         w_capSel;
  logic               w_overflow;

`ifdef STACK_GUARD_EN
  logic r_stackFault;
  logic w_nextFault;
  assign w_overflow  = StackOverFlow;
  // Only issue cycles can fault.
  assign w_nextFault = w_overflow &&
                       ((r_state == ST_PUSH_SEQ) || (r_state == ST_POP_SEQ));
  assign stackFault  = r_stackFault;
`else
  assign w_overflow  = 1'b0;
`endif

  // FINISH accepts like IDLE so back-to-back sequences lose no cycle.
  assign w_accept   = start && isLegalOp(opType) &&
                      ((r_state == ST_IDLE) || (r_state == ST_FINISH));
  assign w_stepInc  = r_stepCnt + 2'd1;
  assign w_lastStep = (r_stepCnt == (stepCount(r_op) - 2'd1));

  // The read issued at step k lands one cycle later, so the word being
  // captured now belongs to step stepCnt-1 (stepCnt runs to N in drain).
  assign w_capSel = popRole(r_op, r_stepCnt - 2'd1);

  always_comb begin
    w_nextState        = r_state;
    w_nextStep         = r_stepCnt;
    w_nextStackOp      = 1'b0;
    w_nextPushPop      = 1'b0;
    w_nextMemWrite     = 1'b0;
    w_nextMemRead      = 1'b0;
    w_nextMemWriteData = r_memWriteData;
    w_nextDone         = 1'b0;
    w_nextPopValid     = 1'b0;
    w_nextPcLoad       = 1'b0;
    w_nextFlagsLoad    = 1'b0;
    w_capEn            = 1'b0;

    case (r_state)
      ST_IDLE, ST_FINISH: begin
        w_nextState = ST_IDLE;
        if (w_accept) begin
          // Step 0 is issued straight from the live inputs in cycle 0.
          w_nextStep    = 2'd0;
          w_nextStackOp = 1'b1;
          if (isPopOp(opType)) begin
            w_nextState   = ST_POP_SEQ;
            w_nextMemRead = 1'b1;
          end else begin
            w_nextState        = ST_PUSH_SEQ;
            w_nextPushPop      = 1'b1;
            w_nextMemWrite     = 1'b1;
            w_nextMemWriteData = pushWord(opType, 2'd0, pcIn, dataIn, flagsIn);
          end
        end
      end

      ST_PUSH_SEQ: begin
        if (w_overflow || w_lastStep) begin
          w_nextState = ST_FINISH;
          w_nextDone  = 1'b1;
        end else begin
          w_nextStep         = w_stepInc;
          w_nextStackOp      = 1'b1;
          w_nextPushPop      = 1'b1;
          w_nextMemWrite     = 1'b1;
          w_nextMemWriteData = pushWord(r_op, w_stepInc, r_pc, dataIn, r_flags);
        end
      end

      ST_POP_SEQ: begin
        w_capEn = (r_stepCnt != 2'd0);
        if (w_overflow) begin
          w_nextState = ST_FINISH;
          w_nextDone  = 1'b1;
        end else begin
          w_nextStep = w_stepInc;
          if (w_lastStep) begin
            w_nextState = ST_POP_DRAIN;
          end else begin
            w_nextStackOp = 1'b1;
            w_nextMemRead = 1'b1;
          end
        end
      end

      ST_POP_DRAIN: begin
        w_capEn         = 1'b1;
        w_nextState     = ST_FINISH;
        w_nextDone      = 1'b1;
        w_nextPopValid  = (r_op == OP_POP);
        w_nextPcLoad    = (r_op == OP_RET) || (r_op == OP_RTI);
        w_nextFlagsLoad = (r_op == OP_RTI);
      end

      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_stepCnt      <= '0;
      r_op           <= '0;
      r_pc           <= '0;
      r_flags        <= '0;
      r_stackOp      <= 1'b0;
      r_pushPop      <= 1'b0;
      r_memWrite     <= 1'b0;
      r_memRead      <= 1'b0;
      r_memWriteData <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_popValid     <= 1'b0;
      r_pcLoad       <= 1'b0;
      r_flagsLoad    <= 1'b0;
`ifdef STACK_GUARD_EN
      r_stackFault   <= 1'b0;
`endif
    end else begin
      r_state        <= w_nextState;
      r_stepCnt      <= w_nextStep;
      r_stackOp      <= w_nextStackOp;
      r_pushPop      <= w_nextPushPop;
      r_memWrite     <= w_nextMemWrite;
      r_memRead      <= w_nextMemRead;
      r_memWriteData <= w_nextMemWriteData;
      r_busy         <= (w_nextState != ST_IDLE);
      r_done         <= w_nextDone;
      r_popValid     <= w_nextPopValid;
      r_pcLoad       <= w_nextPcLoad;
      r_flagsLoad    <= w_nextFlagsLoad;
`ifdef STACK_GUARD_EN
      r_stackFault   <= w_nextFault;
`endif
      // dataIn needs no snapshot: PUSH is a single step issued at accept.
      if (w_accept) begin
        r_op    <= opType;
        r_pc    <= pcIn;
        r_flags <= flagsIn;
      end
    end
  end

  stack_word_asm #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .FLAGS_W (FLAGS_W)
  ) u_wordAsm (
    .clk         (clk),
    .reset       (reset),
    .capEn       (w_capEn),
    .capSel      (w_capSel),
    .memReadData (memReadData),
    .popData     (popData),
    .pcOut       (pcOut),
    .flagsOut    (flagsOut)
  );

  assign stackOp      = r_stackOp;
  assign pushPop      = r_pushPop;
  assign memWrite     = r_memWrite;
  assign memRead      = r_memRead;
  assign memWriteData = r_memWriteData;
  assign busy         = r_busy;
  assign stall        = start | r_busy;
  assign done         = r_done;
  assign popValid     = r_popValid;
  assign pcLoad       = r_pcLoad;
  assign flagsLoad    = r_flagsLoad;

endmodule
`default_nettype wire

// File: tb/tb_stack_seq_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_stack_seq_ctrl
// Description : Directed self-checking bench for stack_seq_ctrl. A small
//               stack memory answers pushes/pops; expected values are
//               hand-computed constants. STACK_GUARD_EN adds the overflow
//               abort scenario.
// Revision    : 1.0  initial release
//============================================================================
module tb_stack_seq_ctrl;
  import stack_defs::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  opType;
  logic [31:0] pcIn;
  logic [15:0] dataIn;
  logic [2:0]  flagsIn;
  logic [15:0] memReadData;
  logic        stackOp, pushPop, memWrite, memRead;
  logic [15:0] memWriteData;
  logic        busy, stall, done, popValid, pcLoad, flagsLoad;
  logic [15:0] popData;
  logic [31:0] pcOut;
  logic [2:0]  flagsOut;
`ifdef STACK_GUARD_EN
  logic        StackOverFlow;
  logic        stackFault;
`endif

  int checks   = 0;
  int failures = 0;

  stack_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opType       (opType),
    .pcIn         (pcIn),
    .dataIn       (dataIn),
    .flagsIn      (flagsIn),
    .memReadData  (memReadData),
`ifdef STACK_GUARD_EN
    .StackOverFlow(StackOverFlow),
    .stackFault   (stackFault),
`endif
    .stackOp      (stackOp),
    .pushPop      (pushPop),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .memWriteData (memWriteData),
    .busy         (busy),
    .stall        (stall),
    .done         (done),
    .popValid     (popValid),
    .popData      (popData),
    .pcLoad       (pcLoad),
    .pcOut        (pcOut),
    .flagsLoad    (flagsLoad),
    .flagsOut     (flagsOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack memory: read data appears the cycle after the pop is issued.
  logic [15:0] mem [16];
  logic [3:0]  sp = 4'd0;
  initial memReadData = 16'h0000;
  always @(posedge clk) begin
    if (stackOp) begin
      if (pushPop) begin
        mem[sp] <= memWriteData;
        sp      <= sp + 4'd1;
      end else begin
        memReadData <= mem[sp - 4'd1];
        sp          <= sp - 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns #1 into cycle 0.
  task automatic issue(input logic [2:0] op, input logic [31:0] pc,
                       input logic [15:0] d, input logic [2:0] f);
    start = 1'b1; opType = op; pcIn = pc; dataIn = d; flagsIn = f;
    #1;
    check("stall_on_start", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; opType = 3'd0; pcIn = '0; dataIn = '0; flagsIn = '0;
  endtask

  task automatic expPush(input string tag, input logic [15:0] d);
    check({tag, ".ctl"},  {28'd0, stackOp, pushPop, memWrite, memRead}, 32'b1110);
    check({tag, ".wd"},   {16'd0, memWriteData}, {16'd0, d});
    check({tag, ".bsd"},  {29'd0, busy, stall, done}, 32'b110);
  endtask

  task automatic expPop(input string tag);
    check({tag, ".ctl"},  {28'd0, stackOp, pushPop, memWrite, memRead}, 32'b1001);
    check({tag, ".bsd"},  {29'd0, busy, stall, done}, 32'b110);
  endtask

  task automatic expQuiet(input string tag, input logic b, input logic d);
    check({tag, ".ctl"},  {29'd0, stackOp, memWrite, memRead}, 32'd0);
    check({tag, ".bd"},   {30'd0, busy, done}, {30'd0, b, d});
  endtask

  task automatic expLoads(input string tag, input logic pv, input logic pl, input logic fl);
    check({tag, ".ld"}, {29'd0, popValid, pcLoad, flagsLoad}, {29'd0, pv, pl, fl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog no finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; opType = 3'd0; pcIn = '0; dataIn = '0; flagsIn = '0;
`ifdef STACK_GUARD_EN
    StackOverFlow = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    expQuiet("rst", 1'b0, 1'b0);
    expLoads("rst", 1'b0, 1'b0, 1'b0);
    check("rst.wd",  {16'd0, memWriteData}, 32'd0);
    check("rst.pc",  pcOut, 32'd0);
    check("rst.pd",  {16'd0, popData}, 32'd0);
    reset = 1'b1;
    nextCycle();

    // INT aborted by reset in cycle 1.
    issue(OP_INT, 32'h1234_5678, 16'h0, 3'b011);
    expPush("int_a0", 16'h1234);
    nextCycle();
    expPush("int_a1", 16'h5678);
    #2 reset = 1'b0;
    #1;
    expQuiet("midrst", 1'b0, 1'b0);
    check("midrst.wd", {16'd0, memWriteData}, 32'd0);
    check("midrst.st", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    nextCycle();

    // PUSH BEEF: one push, done in cycle 1.
    issue(OP_PUSH, 32'h0, 16'hBEEF, 3'b0);
    expPush("push0", 16'hBEEF);
    nextCycle();
    expQuiet("push_done", 1'b1, 1'b1);
    expLoads("push_done", 1'b0, 1'b0, 1'b0);
    nextCycle();
    expQuiet("push_idle", 1'b0, 1'b0);

    // CALL 0012_3456.
    issue(OP_CALL, 32'h0012_3456, 16'h0, 3'b0);
    expPush("call0", 16'h0012);
    nextCycle();
    expPush("call1", 16'h3456);
    nextCycle();
    expQuiet("call_done", 1'b1, 1'b1);
    check("call_done.st", {31'd0, stall}, 32'd1);
    expLoads("call_done", 1'b0, 1'b0, 1'b0);
    nextCycle();

    // RET pops 3456 then 0012.
    issue(OP_RET, 32'h0, 16'h0, 3'b0);
    expPop("ret0");
    nextCycle();
    expPop("ret1");
    nextCycle();
    expQuiet("ret_drain", 1'b1, 1'b0);
    nextCycle();
    expQuiet("ret_done", 1'b1, 1'b1);
    expLoads("ret_done", 1'b0, 1'b1, 1'b0);
    check("ret_done.pc", pcOut, 32'h0012_3456);
    nextCycle();
    expQuiet("ret_idle", 1'b0, 1'b0);

    // INT then RTI accepted back-to-back in INT's done cycle.
    issue(OP_INT, 32'hAAAA_5555, 16'h0, 3'b101);
    expPush("int0", 16'hAAAA);
    nextCycle();
    expPush("int1", 16'h5555);
    nextCycle();
    expPush("int2", 16'h0005);
    nextCycle();
    expQuiet("int_done", 1'b1, 1'b1);
    expLoads("int_done", 1'b0, 1'b0, 1'b0);
    issue(OP_RTI, 32'h0, 16'h0, 3'b0);
    expPop("rti0");
    nextCycle();
    expPop("rti1");
    nextCycle();
    expPop("rti2");
    nextCycle();
    expQuiet("rti_drain", 1'b1, 1'b0);
    nextCycle();
    expQuiet("rti_done", 1'b1, 1'b1);
    expLoads("rti_done", 1'b0, 1'b1, 1'b1);
    check("rti_done.pc", pcOut, 32'hAAAA_5555);
    check("rti_done.fl", {29'd0, flagsOut}, 32'd5);
    nextCycle();
    expLoads("rti_after", 1'b0, 1'b0, 1'b0);

    // POP returns the BEEF pushed earlier.
    issue(OP_POP, 32'h0, 16'h0, 3'b0);
    expPop("pop0");
    nextCycle();
    expQuiet("pop_drain", 1'b1, 1'b0);
    nextCycle();
    expQuiet("pop_done", 1'b1, 1'b1);
    expLoads("pop_done", 1'b1, 1'b0, 1'b0);
    check("pop_done.pd", {16'd0, popData}, 32'h0000_BEEF);
    nextCycle();

    // start while busy is ignored.
    issue(OP_CALL, 32'h0000_7777, 16'h0, 3'b0);
    expPush("callb0", 16'h0000);
    start = 1'b1; opType = OP_POP;
    nextCycle();
    start = 1'b0; opType = 3'd0;
    expPush("callb1", 16'h7777);
    nextCycle();
    expQuiet("callb_done", 1'b1, 1'b1);
    nextCycle();
    expQuiet("callb_idle", 1'b0, 1'b0);

    // Illegal opType in IDLE is ignored.
    start = 1'b1; opType = 3'd7;
    nextCycle();
    start = 1'b0; opType = 3'd0;
    expQuiet("illegal", 1'b0, 1'b0);
    nextCycle();
    expQuiet("illegal2", 1'b0, 1'b0);

`ifdef STACK_GUARD_EN
    // Overflow on CALL step 0 aborts the second push.
    issue(OP_CALL, 32'h0099_0011, 16'h0, 3'b0);
    expPush("gcall0", 16'h0099);
    StackOverFlow = 1'b1;
    nextCycle();
    StackOverFlow = 1'b0;
    expQuiet("gfault", 1'b1, 1'b1);
    check("gfault.sf", {31'd0, stackFault}, 32'd1);
    expLoads("gfault", 1'b0, 1'b0, 1'b0);
    nextCycle();
    expQuiet("gidle", 1'b0, 1'b0);
    check("gidle.sf", {31'd0, stackFault}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
